// File: rtl/sha256_mine_ctrl_if.sv
// Host/datapath-facing signal bundle for the SHA-256 mining sequencer.
// The master side drives job control and the hit flag; the slave side is the controller.
interface sha256_mine_ctrl_if;
    logic        start;
    logic        abort;
    logic [31:0] nonce_start;
    logic [31:0] nonce_end;
    logic        hash_hit;

    logic [5:0]  round;
    logic        load_state;
    logic        round_en;
    logic        w_sel_msg;
    logic        add_digest;
    logic        pass;
    logic        check;
    logic [31:0] nonce;
    logic        busy;
    logic        done;
    logic        found;

    modport master (
        output start, abort, nonce_start, nonce_end, hash_hit,
        input  round, load_state, round_en, w_sel_msg, add_digest, pass,
               check, nonce, busy, done, found
    );

    modport slave (
        input  start, abort, nonce_start, nonce_end, hash_hit,
        output round, load_state, round_en, w_sel_msg, add_digest, pass,
               check, nonce, busy, done, found
    );
endinterface

// File: rtl/sha256_mine_ctrl.sv
// Sequences two 64-round SHA-256 passes per nonce over an inclusive nonce range,
// stopping early on a target hit and reporting done/found to the host.
module sha256_mine_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    sha256_mine_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_CHECK
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  round_q, round_d;
    logic        pass_q, pass_d;
    logic [31:0] nonce_q, nonce_d;
    logic [31:0] nonce_end_q, nonce_end_d;
    logic        found_q, found_d;
    logic        done_q, done_d;
    logic        load_state_q, load_state_d;
    logic        round_en_q, round_en_d;
    logic        w_sel_msg_q, w_sel_msg_d;
    logic        add_digest_q, add_digest_d;
    logic        check_q, check_d;
    logic        busy_q, busy_d;

    always_comb begin
        // NOTE: every _d starts from its _q (done from 0) so no path can infer a latch.
        state_d     = state_q;
        round_d     = round_q;
        pass_d      = pass_q;
        nonce_d     = nonce_q;
        nonce_end_d = nonce_end_q;
        found_d     = found_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d     = S_LOAD;
                    nonce_end_d = bus.nonce_end;
                    nonce_d     = bus.nonce_start;
                    pass_d      = 1'b0;
                    round_d     = 6'd0;
                    found_d     = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                round_d = 6'd0;
            end
            S_ROUND: begin
                if (round_q == 6'd63) begin
                    state_d = S_ADD;
                    round_d = 6'd0;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            S_ADD: begin
                if (!pass_q) begin
                    state_d = S_LOAD;
                    pass_d  = 1'b1;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.hash_hit) begin
                    state_d = S_IDLE;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                end else if (nonce_q == nonce_end_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    nonce_d = nonce_q + 32'd1;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition above, including a hit or end-of-range.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            round_d = 6'd0;
            pass_d  = 1'b0;
            nonce_d = nonce_q;
            found_d = found_q;
            done_d  = 1'b0;
        end

        // NOTE: strobes decode the next state and are then registered, so every output is a flop.
        load_state_d = (state_d == S_LOAD);
        round_en_d   = (state_d == S_ROUND);
        w_sel_msg_d  = (state_d == S_ROUND) && (round_d < 6'd16);
        add_digest_d = (state_d == S_ADD);
        check_d      = (state_d == S_CHECK);
        busy_d       = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            round_q      <= 6'd0;
            pass_q       <= 1'b0;
            nonce_q      <= 32'd0;
            nonce_end_q  <= 32'd0;
            found_q      <= 1'b0;
            done_q       <= 1'b0;
            load_state_q <= 1'b0;
            round_en_q   <= 1'b0;
            w_sel_msg_q  <= 1'b0;
            add_digest_q <= 1'b0;
            check_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            pass_q       <= pass_d;
            nonce_q      <= nonce_d;
            nonce_end_q  <= nonce_end_d;
            found_q      <= found_d;
            done_q       <= done_d;
            load_state_q <= load_state_d;
            round_en_q   <= round_en_d;
            w_sel_msg_q  <= w_sel_msg_d;
            add_digest_q <= add_digest_d;
            check_q      <= check_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.round      = round_q;
    assign bus.load_state = load_state_q;
    assign bus.round_en   = round_en_q;
    assign bus.w_sel_msg  = w_sel_msg_q;
    assign bus.add_digest = add_digest_q;
    assign bus.pass       = pass_q;
    assign bus.check      = check_q;
    assign bus.nonce      = nonce_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.found      = found_q;
endmodule
